// File: rtl/qtcore_a1_tt_top.sv
// QTCore-A1: 8-bit accumulator microcontroller behind a TinyTapeout-style pin wrapper.
// All architectural state forms one serial scan chain that loads programs and unloads debug images.
module qtcore_a1_tt_top #(
  parameter int unsigned MEM_SIZE  = 18,
  parameter int unsigned CHAIN_LEN = 3 + 5 + 8 + 8 + 8 * MEM_SIZE
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int unsigned IO_ADDR = MEM_SIZE - 1;

  typedef enum logic [2:0] {
    FETCH = 3'b001,
    EXEC  = 3'b010,
    HALT  = 3'b100
  } state_t;

  logic clk, rst_n, scan_en_n, proc_en_n, scan_in, btn;
  logic unused_pins;

  assign clk         = io_in[0];
  assign rst_n       = io_in[1];
  assign scan_en_n   = io_in[2];
  assign proc_en_n   = io_in[3];
  assign scan_in     = io_in[4];
  assign btn         = io_in[5];
  assign unused_pins = &{1'b0, io_in[7:6]};

  // State register held as raw bits: scan can load codes outside state_t.
  logic [2:0] state_q, state_d;
  logic [4:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] mem_q [MEM_SIZE];
  logic [7:0] mem_d [MEM_SIZE];

  logic [CHAIN_LEN-1:0] chain;
  logic [CHAIN_LEN-1:0] shifted;
  logic [7:0]           fetch_b;
  logic [7:0]           opnd;

  // Pack all state into the chain order (bit 0 nearest scan_in) and form the shifted image.
  always_comb begin
    chain        = '0;
    chain[2:0]   = state_q;
    chain[7:3]   = pc_q;
    chain[15:8]  = ir_q;
    chain[23:16] = acc_q;
    for (int unsigned k = 0; k < MEM_SIZE; k++) begin
      chain[8*k+24 +: 8] = mem_q[k];
    end
    shifted = {chain[CHAIN_LEN-2:0], scan_in};
  end

  // Memory read ports: instruction fetch by PC (unmapped addresses read 0) and operand by IR[3:0].
  always_comb begin
    fetch_b = '0;
    opnd    = '0;
    for (int unsigned k = 0; k < MEM_SIZE; k++) begin
      if (k == 32'(pc_q))       fetch_b = mem_q[k];
      if (k == 32'(ir_q[3:0])) opnd    = mem_q[k];
    end
  end

  // Next-state: scan shift has priority, then fetch/execute, otherwise hold.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    for (int unsigned k = 0; k < MEM_SIZE; k++) mem_d[k] = mem_q[k];

    if (!scan_en_n) begin
      state_d = shifted[2:0];
      pc_d    = shifted[7:3];
      ir_d    = shifted[15:8];
      acc_d   = shifted[23:16];
      for (int unsigned k = 0; k < MEM_SIZE; k++) mem_d[k] = shifted[8*k+24 +: 8];
    end else if (!proc_en_n) begin
      case (state_q)
        FETCH: begin
          ir_d    = fetch_b;
          pc_d    = pc_q + 5'd1;
          state_d = EXEC;
        end
        EXEC: begin
          state_d = FETCH;
          casez (ir_q)
            8'b0000_????: acc_d = opnd;
            8'b0001_????: begin
              for (int unsigned k = 0; k < MEM_SIZE; k++) begin
                if (k == 32'(ir_q[3:0])) mem_d[k] = acc_q;
              end
            end
            8'b0010_????: acc_d = acc_q + opnd;
            8'b0011_????: acc_d = acc_q - opnd;
            8'b0100_????: acc_d = acc_q & opnd;
            8'b0101_????: acc_d = acc_q | opnd;
            8'b0110_????: acc_d = acc_q ^ opnd;
            8'b0111_0000: acc_d = mem_q[IO_ADDR];
            8'b0111_0001: mem_d[IO_ADDR][7:1] = acc_q[7:1];
            8'b1000_????: if (acc_q == '0) pc_d = pc_q + {ir_q[3], ir_q[3:0]};
            8'b1001_????: if (acc_q != '0) pc_d = pc_q + {ir_q[3], ir_q[3:0]};
            8'b1010_????: pc_d = acc_q[4:0];
            8'b1100_????: acc_d = {ir_q[3:0], 4'h0};
            8'b1110_????: acc_d = acc_q + {4'h0, ir_q[3:0]};
            8'hFF:        state_d = HALT;
            default:      ;
          endcase
        end
        HALT:    ;
        default: state_d = FETCH;
      endcase
      mem_d[IO_ADDR][0] = btn;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      for (int unsigned k = 0; k < MEM_SIZE; k++) mem_q[k] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      for (int unsigned k = 0; k < MEM_SIZE; k++) mem_q[k] <= mem_d[k];
    end
  end

  assign io_out = {mem_q[IO_ADDR][7], mem_q[IO_ADDR][7:1]};

endmodule

// File: tb/tb_qtcore_a1_tt_top.sv
// Bench for qtcore_a1_tt_top: instruction-level model, per-cycle pin compare, scan-image checks.
module tb_qtcore_a1_tt_top;

  logic clk = 1'b0, rst_n = 1'b0, sen_n = 1'b1, pen_n = 1'b1;
  logic sbit = 1'b0, btn = 1'b0, recirc = 1'b0;
  logic [7:0] io_in, io_out;

  assign io_in = {2'b00, btn, (recirc ? io_out[7] : sbit), pen_n, sen_n, rst_n, clk};

  qtcore_a1_tt_top #(.MEM_SIZE(18)) dut (.io_in(io_in), .io_out(io_out));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  bit cmp_en = 1'b0;

  logic [2:0] m_state;
  logic [4:0] m_pc;
  logic [7:0] m_ir, m_acc;
  logic [7:0] m_mem [18];

  task automatic chk(input string nm, input logic [167:0] act, input logic [167:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [167:0] m_pack();
    logic [167:0] v;
    v = '0;
    v[2:0] = m_state; v[7:3] = m_pc; v[15:8] = m_ir; v[23:16] = m_acc;
    for (int k = 0; k < 18; k++) v[8*k+24 +: 8] = m_mem[k];
    return v;
  endfunction

  task automatic m_unpack(input logic [167:0] v);
    m_state = v[2:0]; m_pc = v[7:3]; m_ir = v[15:8]; m_acc = v[23:16];
    for (int k = 0; k < 18; k++) m_mem[k] = v[8*k+24 +: 8];
  endtask

  task automatic m_reset();
    m_state = 3'b001; m_pc = '0; m_ir = '0; m_acc = '0;
    for (int k = 0; k < 18; k++) m_mem[k] = '0;
  endtask

  // Execute the instruction in m_ir following the ISA table.
  task automatic m_exec();
    logic [3:0] a;
    int off;
    a   = m_ir[3:0];
    off = a[3] ? int'(a) - 16 : int'(a);
    if (m_ir == 8'hFF) m_state = 3'b100;
    else begin
      m_state = 3'b001;
      case (m_ir[7:4])
        4'h0: m_acc = m_mem[a];
        4'h1: m_mem[a] = m_acc;
        4'h2: m_acc = m_acc + m_mem[a];
        4'h3: m_acc = m_acc - m_mem[a];
        4'h4: m_acc = m_acc & m_mem[a];
        4'h5: m_acc = m_acc | m_mem[a];
        4'h6: m_acc = m_acc ^ m_mem[a];
        4'h7: if (a == 4'h0) m_acc = m_mem[17];
              else if (a == 4'h1) m_mem[17][7:1] = m_acc[7:1];
        4'h8: if (m_acc == 8'h00) m_pc = 5'((int'(m_pc) + off + 32) % 32);
        4'h9: if (m_acc != 8'h00) m_pc = 5'((int'(m_pc) + off + 32) % 32);
        4'hA: m_pc = m_acc[4:0];
        4'hC: m_acc = {a, 4'h0};
        4'hE: m_acc = m_acc + {4'h0, a};
        default: ;
      endcase
    end
  endtask

  // One clock: drive inputs, advance the model at the rising edge, return at the falling edge.
  task automatic cyc(input logic s_n, input logic p_n, input logic sb, input logic bt, input logic rc);
    logic [167:0] img;
    sen_n = s_n; pen_n = p_n; sbit = sb; btn = bt; recirc = rc;
    @(posedge clk);
    if (!s_n) begin
      img = m_pack();
      img = {img[166:0], (rc ? img[167] : sb)};
      m_unpack(img);
    end else if (!p_n) begin
      case (m_state)
        3'b001: begin
          m_ir = (m_pc < 5'd18) ? m_mem[m_pc] : 8'h00;
          m_pc = m_pc + 5'd1;
          m_state = 3'b010;
        end
        3'b010: m_exec();
        3'b100: ;
        default: m_state = 3'b001;
      endcase
      m_mem[17][0] = bt;
    end
    @(negedge clk);
  endtask

  task automatic scan_load(input logic [167:0] v);
    for (int i = 0; i < 168; i++) cyc(1'b0, 1'b1, v[167-i], 1'b0, 1'b0);
  endtask

  // Read the image while recirculating, so state is preserved.
  task automatic scan_read(output logic [167:0] cap);
    for (int i = 0; i < 168; i++) begin
      cap[167-i] = io_out[7];
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic scan_unload0(output logic [167:0] cap);
    for (int i = 0; i < 168; i++) begin
      cap[167-i] = io_out[7];
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic run(input int n, input logic bt);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, bt, 1'b0);
  endtask

  function automatic logic [167:0] img_of(input logic [2:0] st, input logic [4:0] pc,
                                           input logic [7:0] ir, input logic [7:0] acc);
    logic [167:0] v;
    v = '0;
    v[2:0] = st; v[7:3] = pc; v[15:8] = ir; v[23:16] = acc;
    return v;
  endfunction

  function automatic logic [167:0] setmem(input logic [167:0] v, input int k, input logic [7:0] b);
    logic [167:0] r;
    r = v;
    r[8*k+24 +: 8] = b;
    return r;
  endfunction

  function automatic logic [7:0] fmem(input logic [167:0] v, input int k);
    return v[8*k+24 +: 8];
  endfunction

  // Pins must match the model's I/O byte on every clock outside reset.
  always @(negedge clk) begin
    if (cmp_en && rst_n) chk("io_out", {160'd0, io_out}, {160'd0, m_mem[17][7], m_mem[17][7:1]});
  end

  logic [167:0] cap, v, l1;

  initial begin
    m_reset();
    #12;
    chk("reset_io_out", {160'd0, io_out}, 168'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    scan_read(cap);
    chk("reset_image", cap, 168'd1);
    chk("reset_model", cap, m_pack());

    l1 = img_of(3'b001, 5'd1, 8'hE0, 8'h01);
    for (int k = 0; k < 5; k++) l1 = setmem(l1, k, 8'hE0 + 8'(k));
    l1 = setmem(l1, 17, 8'hF0);
    scan_load(l1);
    chk("load_leds", {160'd0, io_out}, 168'hF8);
    scan_read(cap);
    chk("load_image", cap, l1);

    run(8, 1'b0);
    scan_read(cap);
    chk("run8_acc", {160'd0, cap[23:16]}, 168'h0B);
    chk("run8_pc", {163'd0, cap[7:3]}, 168'd5);
    chk("run8_ir", {160'd0, cap[15:8]}, 168'hE4);
    chk("run8_state", {165'd0, cap[2:0]}, 168'd1);
    chk("run8_model", cap, m_pack());

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    scan_read(cap);
    chk("idle_acc", {160'd0, cap[23:16]}, 168'h0B);
    chk("idle_model", cap, m_pack());

    scan_unload0(cap);
    chk("unload_state", {165'd0, cap[2:0]}, 168'd1);
    chk("unload_pc", {163'd0, cap[7:3]}, 168'd5);
    chk("unload_ir", {160'd0, cap[15:8]}, 168'hE4);
    chk("unload_acc", {160'd0, cap[23:16]}, 168'h0B);
    for (int k = 0; k < 5; k++) chk("unload_mem", {160'd0, fmem(cap, k)}, {160'd0, 8'hE0 + 8'(k)});
    chk("unload_empty_out", {160'd0, io_out}, 168'd0);

    v = img_of(3'b001, 5'd0, 8'h00, 8'h00);
    v = setmem(v, 0, 8'h03); v = setmem(v, 1, 8'h14); v = setmem(v, 2, 8'hFF); v = setmem(v, 3, 8'h5A);
    scan_load(v);
    run(10, 1'b0);
    scan_read(cap);
    chk("sta_mem4", {160'd0, fmem(cap, 4)}, 168'h5A);
    chk("halt_state", {165'd0, cap[2:0]}, 168'd4);
    chk("halt_pc", {163'd0, cap[7:3]}, 168'd3);
    chk("halt_model", cap, m_pack());

    v = setmem(img_of(3'b001, 5'd2, 8'h00, 8'h00), 2, 8'h8E);
    scan_load(v);
    run(2, 1'b0);
    scan_read(cap);
    chk("beqz_taken_pc", {163'd0, cap[7:3]}, 168'd1);
    v = setmem(img_of(3'b001, 5'd2, 8'h00, 8'h01), 2, 8'h8E);
    scan_load(v);
    run(2, 1'b0);
    scan_read(cap);
    chk("beqz_not_taken_pc", {163'd0, cap[7:3]}, 168'd3);
    chk("beqz_model", cap, m_pack());

    scan_load(img_of(3'b011, 5'd7, 8'h00, 8'h00));
    run(1, 1'b0);
    scan_read(cap);
    chk("illegal_state", {165'd0, cap[2:0]}, 168'd1);
    chk("illegal_pc", {163'd0, cap[7:3]}, 168'd7);

    v = img_of(3'b001, 5'd0, 8'h00, 8'h00);
    v = setmem(v, 0, 8'hC5); v = setmem(v, 1, 8'h2B); v = setmem(v, 2, 8'h3C);
    v = setmem(v, 3, 8'h4D); v = setmem(v, 4, 8'h5E); v = setmem(v, 5, 8'h6F);
    v = setmem(v, 6, 8'h71); v = setmem(v, 7, 8'h70); v = setmem(v, 8, 8'hE1);
    v = setmem(v, 9, 8'h96); v = setmem(v, 16, 8'hA0);
    v = setmem(v, 11, 8'h33); v = setmem(v, 12, 8'h01); v = setmem(v, 13, 8'hF3);
    v = setmem(v, 14, 8'h0C); v = setmem(v, 15, 8'hFF);
    scan_load(v);
    run(24, 1'b1);
    chk("mix_leds", {160'd0, io_out}, 168'h38);
    scan_read(cap);
    chk("mix_acc", {160'd0, cap[23:16]}, 168'hC5);
    chk("mix_pc", {163'd0, cap[7:3]}, 168'd19);
    chk("mix_io_byte", {160'd0, fmem(cap, 17)}, 168'h71);
    chk("mix_model", cap, m_pack());

    scan_load(l1);
    run(3, 1'b0);
    sen_n = 1'b1; pen_n = 1'b1; recirc = 1'b0;
    chk("pre_rst_io", {160'd0, io_out}, 168'hF8);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_io", {160'd0, io_out}, 168'd0);
    m_reset();
    #1 rst_n = 1'b1;
    @(negedge clk);
    scan_read(cap);
    chk("async_rst_image", cap, 168'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
